// File: rtl/fpu_pkg.sv
// Shared FPU constants and the packed single-precision layout.
// Used by itof_pipe and the float-to-int path.
package fpu_pkg;

  localparam int unsigned FP_EW = 8;
  localparam int unsigned FP_MW = 23;

  localparam logic [FP_EW-1:0] FP_BIAS       = 8'd127;
  // Exponent of a value whose leading one sits at bit 31.
  localparam logic [FP_EW-1:0] ITOF_EXP_BASE = 8'd158;

  typedef struct packed {
    logic             s;
    logic [FP_EW-1:0] e;
    logic [FP_MW-1:0] m;
  } fp32_t;

endpackage

// File: rtl/lzc32.sv
// Combinational 32-bit leading-zero counter; returns 32 for an all-zero input.
module lzc32 (
  input  logic [31:0] a,
  output logic [5:0]  cnt
);

  // The highest set bit is visited last, so its count wins.
  always_comb begin
    cnt = 6'd32;
    for (int i = 0; i < 32; i++) begin
      if (a[i]) cnt = 6'(31 - i);
    end
  end

endmodule

// File: rtl/itof_pipe.sv
// Three-stage signed int32 to IEEE-754 single converter with valid/ready on both sides.
// Define ITOF_RNE_EN for round-to-nearest-even; otherwise the mantissa is truncated.
module itof_pipe
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y,
  output logic        inexact
);

  logic adv1, adv2, adv3;

  logic        v1_q, v2_q, v3_q;
  logic        s1_q, s2_q;
  logic [31:0] mag1_q;
  logic [30:0] norm2_q;
  logic [FP_EW-1:0] e2_q;
  logic        zero2_q;
  fp32_t       y3_q;
  logic        inx3_q;

  logic [31:0] mag_d;
  logic [5:0]  lz;
  logic [30:0] norm_d;
  logic [FP_EW-1:0] e_d;

  logic [FP_MW-1:0] m_raw, m_fin;
  logic             g, st;
  logic [FP_EW-1:0] e_fin;
  fp32_t            y_d;
  logic             inx_d;

  // Bubbles collapse: a stage advances if downstream moves or it is empty.
  assign adv3     = out_ready | ~v3_q;
  assign adv2     = adv3 | ~v2_q;
  assign adv1     = adv2 | ~v1_q;
  assign in_ready = adv1;

  // S1: sign/magnitude; -2^31 maps to 0x80000000 as unsigned.
  assign mag_d = x[31] ? (~x + 32'd1) : x;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v1_q   <= 1'b0;
      s1_q   <= 1'b0;
      mag1_q <= '0;
    end else if (adv1) begin
      v1_q   <= in_valid;
      s1_q   <= x[31];
      mag1_q <= mag_d;
    end
  end

  // S2: normalize so the leading one lands on bit 31 (only bits below it are kept).
  lzc32 u_lzc (
    .a   (mag1_q),
    .cnt (lz)
  );

  assign norm_d = mag1_q[30:0] << lz;
  assign e_d    = ITOF_EXP_BASE - {2'b00, lz};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v2_q    <= 1'b0;
      s2_q    <= 1'b0;
      norm2_q <= '0;
      e2_q    <= '0;
      zero2_q <= 1'b0;
    end else if (adv2) begin
      v2_q    <= v1_q;
      s2_q    <= s1_q;
      norm2_q <= norm_d;
      e2_q    <= e_d;
      zero2_q <= (mag1_q == 32'd0);
    end
  end

  // S3: round and pack.
  assign m_raw = norm2_q[30:8];
  assign g     = norm2_q[7];
  assign st    = |norm2_q[6:0];

`ifdef ITOF_RNE_EN
  logic rup, carry;
  assign rup = g & (st | m_raw[0]);
  // A carry out of the mantissa wraps it to zero and bumps the exponent.
  assign {carry, m_fin} = {1'b0, m_raw} + {{FP_MW{1'b0}}, rup};
  assign e_fin = e2_q + {{(FP_EW-1){1'b0}}, carry};
`else
  assign m_fin = m_raw;
  assign e_fin = e2_q;
`endif

  always_comb begin
    y_d   = '{s: s2_q, e: e_fin, m: m_fin};
    inx_d = g | st;
    if (zero2_q) begin
      y_d   = '0;
      inx_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v3_q   <= 1'b0;
      y3_q   <= '0;
      inx3_q <= 1'b0;
    end else if (adv3) begin
      v3_q   <= v2_q;
      y3_q   <= y_d;
      inx3_q <= inx_d;
    end
  end

  assign out_valid = v3_q;
  assign y         = y3_q;
  assign inexact   = inx3_q;

endmodule

// File: tb/tb_itof_pipe.sv
// Self-checking bench for itof_pipe: directed vectors, backpressure, reset and a random sweep.
// Expected values follow ITOF_RNE_EN the same way the design does.
module tb_itof_pipe;

  logic        clk;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;
  logic        inexact;

  int checks;
  int errors;

  itof_pipe dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .inexact   (inexact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] xi;
    logic [31:0] ey;
    logic        ei;
  } vec_t;

  vec_t        vecs[8];
  logic [32:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: locate the top bit, split off the discarded remainder, round by comparing
  // the remainder against half an ulp. Returns {inexact, y}.
  function automatic logic [32:0] ref_cvt(input logic [31:0] xi);
    logic              s;
    longint unsigned   mag, q, rem, half;
    int                p, sh;
    logic [7:0]        e;
    logic              inx;
    s   = xi[31];
    mag = s ? (64'h1_0000_0000 - {32'd0, xi}) : {32'd0, xi};
    if (mag == 0) return 33'd0;
    p = 31;
    while (((mag >> p) & 64'd1) == 0) p--;
    rem = 0;
    if (p <= 23) begin
      q = mag << (23 - p);
    end else begin
      sh   = p - 23;
      q    = mag >> sh;
      rem  = mag - (q << sh);
      half = 64'd1 << (sh - 1);
`ifdef ITOF_RNE_EN
      if (rem > half || (rem == half && q[0])) q = q + 1;
      if (q == 64'd16777216) begin
        q = q >> 1;
        p = p + 1;
      end
`else
      if (half == 0) q = q; // no rounding in the truncating build
`endif
    end
    inx = (rem != 0);
    e   = 8'(p + 127);
    return {inx, s, e, q[22:0]};
  endfunction

  function automatic logic [31:0] rand_x();
    logic [31:0] r;
    case ($urandom_range(0, 3))
      0: r = $urandom;
      1: r = 32'($urandom_range(0, 400)) - 32'd200;
      2: r = ($urandom | 32'h0100_0000) & 32'h01FF_FFFF;
      default: begin
        r = $urandom >> $urandom_range(0, 31);
        if ($urandom_range(0, 7) == 0) r = 32'h8000_0000;
        if ($urandom_range(0, 7) == 0) r = 32'h7FFF_FFFF;
      end
    endcase
    return r;
  endfunction

  // Send one operand into an empty pipe and check latency and result.
  task automatic send_chk(input string nm, input logic [31:0] xi, input logic [31:0] ey,
                          input logic ei);
    in_valid  = 1'b1;
    x         = xi;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({nm, "_lat1"}, {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    chk({nm, "_lat2"}, {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    chk({nm, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({nm, "_y"}, y, ey);
    chk({nm, "_inexact"}, {31'd0, inexact}, {31'd0, ei});
  endtask

  logic [31:0] bp_vals[4];
  logic [31:0] bp_exp[4];
  logic [31:0] got[$];
  int          got_cyc[$];
  logic [32:0] held, e33;
  logic        hold_pend;
  int          idx, acc;
  logic        accd;

  initial begin
    checks    = 0;
    errors    = 0;
    rstn      = 1'b0;
    in_valid  = 1'b0;
    x         = '0;
    out_ready = 1'b0;

    vecs[0] = '{32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[1] = '{32'h0000_0001, 32'h3F80_0000, 1'b0};
    vecs[2] = '{32'hFFFF_FFFF, 32'hBF80_0000, 1'b0};
    vecs[3] = '{32'h8000_0000, 32'hCF00_0000, 1'b0};
`ifdef ITOF_RNE_EN
    vecs[4] = '{32'h7FFF_FFFF, 32'h4F00_0000, 1'b1};
    vecs[6] = '{32'h0100_0003, 32'h4B80_0002, 1'b1};
`else
    vecs[4] = '{32'h7FFF_FFFF, 32'h4EFF_FFFF, 1'b1};
    vecs[6] = '{32'h0100_0003, 32'h4B80_0001, 1'b1};
`endif
    vecs[5] = '{32'h0100_0001, 32'h4B80_0000, 1'b1};
    vecs[7] = '{32'h0000_0010, 32'h4180_0000, 1'b0};

    bp_vals = '{32'h10, 32'h20, 32'h30, 32'h40};
    bp_exp  = '{32'h4180_0000, 32'h4200_0000, 32'h4240_0000, 32'h4280_0000};

    repeat (2) @(posedge clk);
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_y", y, 32'd0);
    chk("rst_inexact", {31'd0, inexact}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < 8; i++) begin
      send_chk($sformatf("vec%0d", i), vecs[i].xi, vecs[i].ey, vecs[i].ei);
    end
    @(posedge clk); #1;

    // Backpressure: out_ready low for six cycles while offering four operands.
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = (idx < 4);
      x        = (idx < 4) ? bp_vals[idx] : 32'd0;
      #1;
      accd = in_valid && in_ready;
      @(posedge clk); #1;
      if (accd) idx++;
    end
    chk("bp_accepts", 32'(idx), 32'd3);
    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_hold_y", y, 32'h4180_0000);
    out_ready = 1'b1;
    for (int c = 0; c < 12 && got.size() < 4; c++) begin
      in_valid = (idx < 4);
      x        = (idx < 4) ? bp_vals[idx] : 32'd0;
      #1;
      if (out_valid) begin
        got.push_back(y);
        got_cyc.push_back(c);
      end
      accd = in_valid && in_ready;
      @(posedge clk); #1;
      if (accd) idx++;
    end
    in_valid = 1'b0;
    chk("bp_count", 32'(got.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < got.size()) chk($sformatf("bp_out%0d", i), got[i], bp_exp[i]);
    end
    if (got.size() == 4) chk("bp_back_to_back", 32'(got_cyc[3] - got_cyc[0]), 32'd3);
    repeat (3) @(posedge clk);
    #1;

    // Reset with three operands in flight.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      x = bp_vals[i];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("mid_full", {31'd0, out_valid}, 32'd1);
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_y", y, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk) rstn = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("mid_no_stale", {31'd0, out_valid}, 32'd0);
    end
    send_chk("post_rst", 32'd2, 32'h4000_0000, 1'b0);
    @(posedge clk); #1;

    // Random sweep against the reference model.
    acc       = 0;
    hold_pend = 1'b0;
    held      = '0;
    for (int c = 0; c < 40000 && acc < 10000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      x         = rand_x();
      out_ready = ($urandom_range(0, 9) < 7);
      #1;
      if (hold_pend) chk("rnd_hold", y, held[31:0]);
      hold_pend = out_valid && !out_ready;
      held      = {inexact, y};
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("rnd_unexpected_out", 32'd1, 32'd0);
        end else begin
          e33 = exp_q.pop_front();
          chk("rnd_y", y, e33[31:0]);
          chk("rnd_inexact", {31'd0, inexact}, {31'd0, e33[32]});
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_cvt(x));
        acc++;
      end
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 10 && exp_q.size() > 0; c++) begin
      #1;
      if (out_valid) begin
        e33 = exp_q.pop_front();
        chk("drain_y", y, e33[31:0]);
        chk("drain_inexact", {31'd0, inexact}, {31'd0, e33[32]});
      end
      @(posedge clk); #1;
    end
    chk("rnd_accepts", 32'(acc), 32'd10000);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
